// File: rtl/reg_bank_reader_pkg.sv
// Shared definitions for the enable/clear register bank control (read and write side).
package reg_bank_reader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    FIN  = 2'd3
  } state_t;

  // Smallest width w with 2**w >= n (n >= 1).
  function automatic int clog2_of(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  function automatic int addr_width(input int numreg);
    return clog2_of(numreg);
  endfunction

  // A transfer length must be able to express numreg itself.
  function automatic int cnt_width(input int numreg);
    return clog2_of(numreg + 1);
  endfunction

endpackage

// File: rtl/reg_bank_reader_enreg.sv
// Enable/clear register: synchronous clear beats enable, async active-high reset.
module reg_bank_reader_enreg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/reg_bank_reader.sv
// Walks a window of bank entries and streams each word out over valid/ready.
module reg_bank_reader
  import reg_bank_reader_pkg::*;
#(
  parameter int SIZEDATA = 32,
  parameter int NUMREG   = 16,
  parameter int ADDRW    = addr_width(NUMREG),
  parameter int CNTW     = cnt_width(NUMREG)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                start,
  input  logic [ADDRW:0]      base,
  input  logic [CNTW-1:0]     count,
  output logic [ADDRW-1:0]    rd_addr,
  input  logic [SIZEDATA-1:0] rd_data,
  output logic [SIZEDATA-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic                done,
  output logic                err
);

  state_t          state;
  logic [CNTW-1:0] remaining;
  logic            load;

  // An abort landing in LOAD must leave the previous word in place.
  assign load = (state == LOAD) && !clear;

  reg_bank_reader_enreg #(.W(SIZEDATA)) u_out_reg (
    .clk   (clk),
    .reset (reset),
    .en    (load),
    .clr   (1'b0),
    .d     (rd_data),
    .q     (out_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      rd_addr   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      remaining <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (base[ADDRW]) begin
              state <= FIN;
              done  <= 1'b1;
              err   <= 1'b1;
            end else if (count == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              rd_addr   <= base[ADDRW-1:0];
              remaining <= count;
              state     <= LOAD;
            end
          end
        end
        LOAD: begin
          out_valid <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            remaining <= remaining - CNTW'(1);
            if (remaining == CNTW'(1)) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              rd_addr <= rd_addr + ADDRW'(1);
              state   <= LOAD;
            end
          end
        end
        FIN: begin
          done  <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bank_reader.sv
// Directed vectors for reg_bank_reader against a bank preloaded with 0xA0+i.
module tb_reg_bank_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  base = '0;
  logic [4:0]  count = '0;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy, done, err;

  logic [31:0] bank [16];
  assign rd_data = bank[rd_addr];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_bank_reader dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .start     (start),
    .base      (base),
    .count     (count),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  typedef struct {
    logic [4:0] base;
    logic [4:0] count;
    logic       exp_err;
    int         exp_lat;    // edges after the start edge until done is visible
    int         exp_words;
    int         stall_word; // -1: never stall
    int         stall_len;
    bit         poke;       // fire a stray start mid-transfer
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic run_xfer(input vec_t v);
    int cyc, words, stall, first_valid;
    bit got_done, saw_valid;
    logic [3:0] a;
    @(negedge clk);
    start = 1'b1; base = v.base; count = v.count; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; words = 0; stall = 0; first_valid = -1; got_done = 0; saw_valid = 0;
    while (!got_done && cyc < v.exp_lat + 20) begin
      start = (v.poke && cyc == 3);
      if (start) begin base = 5'd0; count = 5'd1; end
      check("busy_run", busy, 1'b1);
      if (out_valid) begin
        if (!saw_valid) first_valid = cyc;
        saw_valid = 1;
        a = 4'(int'(v.base[3:0]) + words);
        if (words == v.stall_word && stall < v.stall_len) begin
          out_ready = 1'b0;
          if (stall == 0) bank[a] = 32'hDEAD_BEEF;
          check("stall_data", out_data, 32'hA0 + 32'(a));
          if (stall == v.stall_len - 1) bank[a] = 32'hA0 + 32'(a);
          stall++;
        end else begin
          out_ready = 1'b1;
          check("word", out_data, 32'hA0 + 32'(a));
          check("rd_addr", 32'(rd_addr), 32'(a));
          words++;
        end
      end
      if (done) begin
        got_done = 1;
        check("done_lat", cyc, v.exp_lat);
        check("err", err, v.exp_err);
        check("word_cnt", words, v.exp_words);
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    check("done_seen", got_done, 1'b1);
    check("saw_valid", saw_valid, v.exp_words > 0);
    if (v.exp_words > 0) check("first_valid_lat", first_valid, 1);
    check("done_pulse", done, 1'b0);
    check("err_pulse", err, 1'b0);
    check("busy_idle", busy, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) bank[i] = 32'hA0 + 32'(i);
    //        base   count  err  lat words stall len poke
    vecs[0] = '{5'd3,  5'd4,  0,  8,  4, -1, 0, 0};
    vecs[1] = '{5'd14, 5'd4,  0,  8,  4, -1, 0, 0};
    vecs[2] = '{5'd0,  5'd0,  0,  0,  0, -1, 0, 0};
    vecs[3] = '{5'd16, 5'd4,  1,  0,  0, -1, 0, 0};
    vecs[4] = '{5'd15, 5'd1,  0,  2,  1, -1, 0, 0};
    vecs[5] = '{5'd5,  5'd18, 0, 36, 18, -1, 0, 0};
    vecs[6] = '{5'd31, 5'd0,  1,  0,  0, -1, 0, 0};
    vecs[7] = '{5'd3,  5'd4,  0, 13,  4,  1, 5, 0};
    vecs[8] = '{5'd9,  5'd3,  0,  6,  3, -1, 0, 1};

    #1;
    check("rst_addr", 32'(rd_addr), 0);
    check("rst_data", out_data, 0);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) run_xfer(vecs[i]);

    // clear during the second word together with a handshake
    @(negedge clk);
    start = 1'b1; base = 5'd3; count = 5'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("clr_pre_valid", out_valid, 1'b1);
    check("clr_pre_data", out_data, 32'hA4);
    clear = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr_valid", out_valid, 1'b0);
    check("clr_busy", busy, 1'b0);
    check("clr_done", done, 1'b0);
    check("clr_addr_hold", 32'(rd_addr), 4);
    check("clr_data_hold", out_data, 32'hA4);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("clr_no_done", done, 1'b0);
      check("clr_no_valid", out_valid, 1'b0);
    end
    run_xfer(vecs[1]);

    // async reset in the LOAD cycle, checked before the next edge
    @(negedge clk);
    start = 1'b1; base = 5'd7; count = 5'd2;
    @(negedge clk);
    start = 1'b0;
    check("load_busy", busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("arst_addr", 32'(rd_addr), 0);
    check("arst_data", out_data, 0);
    check("arst_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_err", err, 0);
    @(negedge clk);
    reset = 1'b0;
    run_xfer(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_bank_reader.md
Name: reg_bank_reader

Overview:
- Read-side counterpart of the coprocessor's enable/clear register bank.
- On a start command, walks a contiguous window of bank entries and streams each word out over a valid/ready handshake to the host back-end.
- Sits between the bank's combinational read mux and the output interface.
- Generates bank addresses, holds each word in an output register, and signals completion or a bad request.

Parameters:
SIZEDATA, 32, data word width (matches bank register width)
NUMREG, 16, number of bank entries, power of two, >=2
ADDRW, 4, address width, must equal clog2(NUMREG)
CNTW, 5, transfer length width, must hold NUMREG

Ports:
clk  in  1  system clock
reset  in  1  system reset
clear  in  1  synchronous internal abort
start  in  1  request pulse, sampled only in IDLE
base  in  ADDRW+1  first bank index; MSB set = out of range
count  in  CNTW  number of words to read
rd_addr  out  ADDRW  registered bank read address
rd_data  in  SIZEDATA  combinational bank read data for rd_addr
out_data  out  SIZEDATA  streamed word
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts
busy  out  1  high in any state except IDLE
done  out  1  one-cycle completion pulse
err  out  1  one-cycle bad-request pulse, coincident with done

Behaviour:
- Reset: reset, asynchronous, active-high; clock clk. All outputs are 0 at reset: rd_addr, out_data, out_valid, busy, done, err. State = IDLE, remaining = 0.
- FSM states: IDLE, LOAD, SEND, FIN.
- IDLE:
  - start with base MSB set -> FIN, err raised in FIN.
  - start with count==0 -> FIN, no err.
  - Any other start -> rd_addr<=base[ADDRW-1:0], remaining<=count, go LOAD.
- LOAD (one cycle): out_data<=rd_data, out_valid<=1, go SEND.
- SEND:
  - out_valid holds and out_data is stable until out_ready.
  - On out_valid&&out_ready with remaining==1: out_valid<=0, go FIN.
  - On out_valid&&out_ready otherwise: out_valid<=0, rd_addr<=rd_addr+1 (wraps modulo NUMREG: 15 -> 0), remaining<=remaining-1, go LOAD.
- FIN: done=1 for exactly one cycle (err=1 too if bad request), then IDLE.
- Throughput: 2 cycles per word with out_ready held high.
- Latency: start -> first out_valid = 2 cycles. Last handshake -> done = 1 cycle.
- count > NUMREG is legal: addresses wrap and entries are re-read.
- start outside IDLE is ignored, with no queuing.
- clear, synchronous, overrides all other inputs in any state:
  - state IDLE, out_valid 0, remaining 0.
  - no done or err pulse.
  - rd_addr and out_data hold their values.
  - Takes priority over a simultaneous start and a simultaneous handshake; that word is dropped.
- reset mid-transfer returns everything to reset values immediately.
- out_data is captured only in LOAD. Bank writes during SEND do not alter the word in flight.

Decomposition:
- Shared package: FSM state encoding constants (IDLE=0, LOAD=1, SEND=2, FIN=3) and the ADDRW/CNTW derivation helper, shared with the bank write-side control.
- No sub-module needed. The output holding register is an instance of the existing enable/clear register: enable = LOAD, clear = 0, datain = rd_data.

Test Plan:
- Bank[i]=0xA0+i, start base=3 count=4, out_ready=1 -> out_data 0xA3,0xA4,0xA5,0xA6 on cycles 2,4,6,8 after start; done pulse cycle 9; err=0.
- base=14 count=4 -> rd_addr 14,15,0,1; data 0xAE,0xAF,0xA0,0xA1.
- out_ready low for 5 cycles on the second word -> out_valid held high and out_data=0xA4 stable throughout; no skipped or duplicated words.
- start count=0 -> busy for 1 cycle, done=1, err=0, out_valid never asserted. start base=16 (MSB set) -> done=1, err=1 one cycle later.
- clear asserted in SEND during the second word, together with out_ready=1 -> next cycle IDLE, out_valid=0, busy=0, no done. A new start then runs normally.
- start pulses while busy are ignored. Async reset asserted mid-LOAD -> all outputs 0 without a clock edge.
